// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM encoding,
// requester ids and the default fetch-starvation bound.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int STARVE_MAX_DEF = 4;

  function automatic arb_state_e busy_state(input logic port);
    return (port == PORT_DM) ? ST_BUSY_DM : ST_BUSY_IF;
  endfunction

endpackage

// File: rtl/arb_streak_cnt.sv
// Saturating count of data grants made while fetch was left waiting.
import mem_arb_pkg::*;

module arb_streak_cnt #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != MAXV) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q == MAXV);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: data has
// priority, fetch is guaranteed a grant after STARVE_MAX consecutive data wins.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_e      state_q;
  logic            mem_req_q, mem_we_q;
  logic [DW/8-1:0] mem_be_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic            if_ready_q, dm_ready_q, flush_pend_q;

  logic cand_if, cand_dm, gnt, gnt_port, sat, streak_inc, streak_clr, if_drop;

  // A port whose ready pulses this cycle was just served; its req is stale.
  assign cand_if    = if_req & ~if_ready_q;
  assign cand_dm    = dm_req & ~dm_ready_q;
  assign gnt        = (state_q == ST_IDLE) & (cand_if | cand_dm);
  assign gnt_port   = (cand_dm & ~(cand_if & sat)) ? PORT_DM : PORT_IF;
  assign streak_inc = gnt & (gnt_port == PORT_DM) & if_req;
  assign streak_clr = gnt & ~streak_inc;
  assign if_drop    = flush_pend_q | if_flush;

  arb_streak_cnt #(.STARVE_MAX(STARVE_MAX)) u_streak (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (streak_inc),
    .clr_i (streak_clr),
    .sat_o (sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          flush_pend_q <= 1'b0;
          if (gnt) begin
            state_q   <= busy_state(gnt_port);
            mem_req_q <= 1'b1;
            if (gnt_port == PORT_DM) begin
              mem_we_q    <= dm_we;
              mem_be_q    <= dm_be;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_be_q    <= '1;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        ST_BUSY_IF: begin
          if (if_flush) flush_pend_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
            // A redirected fetch still drains the memory but is never delivered.
            if (!if_drop) begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end
          end
        end
        ST_BUSY_DM: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            state_q    <= ST_IDLE;
            dm_ready_q <= 1'b1;
            if (!mem_we_q) dm_rdata_q <= mem_rdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SM = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW/8-1:0] dm_be = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic if_ready, dm_ready, mem_req, mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, the fetch-starvation streak, and the
  // values each output should show in the current cycle.
  int m_busy = -1, m_streak = 0;
  bit m_flush = 0;
  logic e_req = 0, e_we = 0, e_ifr = 0, e_dmr = 0;
  logic [DW/8-1:0] e_be = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_ifd = '0, e_dmd = '0;

  task automatic mdl_rst();
    m_busy = -1; m_streak = 0; m_flush = 0;
    e_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
    e_ifr = 0; e_dmr = 0; e_ifd = '0; e_dmd = '0;
  endtask

  task automatic mdl_step();
    bit want_if, want_dm;
    want_if = if_req && !e_ifr;
    want_dm = dm_req && !e_dmr;
    e_ifr = 0; e_dmr = 0;
    if (m_busy < 0) begin
      m_flush = 0;
      if (want_dm && !(want_if && m_streak == SM)) begin
        m_streak = if_req ? ((m_streak < SM) ? m_streak + 1 : SM) : 0;
        m_busy = 1; e_req = 1;
        e_we = dm_we; e_be = dm_be; e_addr = dm_addr; e_wdata = dm_wdata;
      end else if (want_if) begin
        m_streak = 0; m_busy = 0; e_req = 1;
        e_we = 0; e_addr = if_addr;
      end
    end else begin
      if (m_busy == 0 && if_flush) m_flush = 1;
      if (mem_ack) begin
        if (m_busy == 0 && !m_flush) begin e_ifd = mem_rdata; e_ifr = 1; end
        if (m_busy == 1) begin
          e_dmr = 1;
          if (!e_we) e_dmd = mem_rdata;
        end
        m_busy = -1; e_req = 0; m_flush = 0;
      end
    end
  endtask

  // Memory responder: fixed or random wait, deterministic or random data.
  int mwait = 0, wcnt = 0;
  bit mrand = 0, in_txn = 0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    case (a)
      32'h10:  return 32'h55;
      32'h80:  return 32'h2008000C;
      default: return a ^ 32'hC0DE0000;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!rstn) mdl_rst(); else mdl_step();
    @(negedge clk);
    chk("mem_req", mem_req, e_req);
    chk("if_ready", if_ready, e_ifr);
    chk("dm_ready", dm_ready, e_dmr);
    chk("if_rdata", if_rdata, e_ifd);
    chk("dm_rdata", dm_rdata, e_dmd);
    chk("rdy_both", if_ready & dm_ready, 1'b0);
    if (e_req) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      if (m_busy == 1) begin
        chk("mem_be", mem_be, e_be);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
    if (!rstn) begin
      in_txn = 0; mem_ack = 0;
    end else if (mem_req) begin
      if (!in_txn) begin
        in_txn = 1;
        wcnt = (mwait < 0) ? $urandom_range(0, 3) : mwait;
      end
      if (wcnt == 0) begin
        mem_ack = 1; in_txn = 0;
        mem_rdata = mrand ? $urandom : mem_val(mem_addr);
      end else begin
        wcnt--; mem_ack = 0; mem_rdata = $urandom;
      end
    end else begin
      mem_ack = mrand && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  endtask

  initial begin
    logic [DW-1:0] prev_if;
    logic [6:0] ord;
    int ngr, ndm;
    bit prev_req, if_done;

    repeat (2) cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rstn = 1;
    cyc();

    // single zero-wait fetch
    if_req = 1; if_addr = 32'h80;
    cyc(); chk("f_mreq", mem_req, 1); chk("f_maddr", mem_addr, 32'h80);
    cyc(); chk("f_ready", if_ready, 1); chk("f_data", if_rdata, 32'h2008000C);
    chk("f_dm_quiet", dm_ready, 0);
    if_req = 0;
    cyc();

    // simultaneous requests: data first, fetch granted in the dm_ready cycle
    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    cyc(); chk("p_addr_dm", mem_addr, 32'h10);
    cyc(); chk("p_dm_ready", dm_ready, 1); chk("p_dm_data", dm_rdata, 32'h55);
    chk("p_if_wait", if_ready, 0);
    dm_req = 0;
    cyc(); chk("p_mreq_if", mem_req, 1); chk("p_addr_if", mem_addr, 32'h100);
    cyc(); chk("p_if_ready", if_ready, 1); chk("p_if_data", if_rdata, mem_val(32'h100));
    if_req = 0;
    cyc();

    // store leaves load data untouched
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    cyc(); chk("s_we", mem_we, 1); chk("s_be", mem_be, 4'hF);
    chk("s_addr", mem_addr, 32'h20); chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    cyc(); chk("s_ready", dm_ready, 1); chk("s_keep", dm_rdata, 32'h55);
    dm_req = 0; dm_we = 0;
    cyc();

    // flushed fetch with two memory wait cycles, then redirected fetch
    prev_if = if_rdata; mwait = 2; if_req = 1; if_addr = 32'h84;
    cyc(); chk("fl_rdy1", if_ready, 0);
    cyc(); chk("fl_rdy2", if_ready, 0); if_flush = 1;
    cyc(); chk("fl_rdy3", if_ready, 0); if_flush = 0;
    cyc(); chk("fl_rdy4", if_ready, 0); chk("fl_mreq", mem_req, 0);
    chk("fl_keep", if_rdata, prev_if);
    mwait = 0; if_addr = 32'h200;
    cyc(); chk("fl_next_req", mem_req, 1); chk("fl_next_addr", mem_addr, 32'h200);
    cyc(); chk("fl_next_rdy", if_ready, 1); chk("fl_next_data", if_rdata, mem_val(32'h200));
    if_req = 0;
    cyc();

    // reset while a load is waiting for an ack that never comes
    mwait = 1000; dm_req = 1; dm_we = 0; dm_addr = 32'h30;
    cyc(); chk("ro_busy", mem_req, 1);
    cyc();
    #2 rstn = 0; mdl_rst();
    #1 chk("ro_mreq", mem_req, 0); chk("ro_dm_rdy", dm_ready, 0); chk("ro_if_rdy", if_ready, 0);
    dm_req = 0; in_txn = 0; mwait = 0;
    cyc(); rstn = 1; if_req = 1; if_addr = 32'h40;
    cyc(); cyc(); chk("ro_if_done", if_ready, 1); chk("ro_if_data", if_rdata, mem_val(32'h40));
    if_req = 0;
    cyc();

    // fetch steps aside in each dm_ready cycle so the streak can build up
    ord = '0; ngr = 0; ndm = 1; prev_req = 0; if_done = 0;
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    for (int c = 0; c < 60 && ngr < 7; c++) begin
      cyc();
      if (mem_req && !prev_req) begin ord = {ord[5:0], mem_addr != 32'h80}; ngr++; end
      prev_req = mem_req;
      if (dm_ready) begin
        if_req = 0;
        if (ndm < 6) begin ndm++; dm_addr = dm_addr + 4; end
        else dm_req = 0;
      end else if (!if_done) if_req = 1;
      if (if_ready) begin if_done = 1; if_req = 0; end
    end
    chk("starve_grants", ngr, 7);
    chk("starve_order", ord, 7'b1111011);
    cyc(); dm_req = 0; if_req = 0;
    cyc();

    // random traffic
    mrand = 1; mwait = -1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (if_ready || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if (if_req) if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
      if_flush = ($urandom_range(0, 7) == 0);
      if (dm_ready || !dm_req) begin
        dm_req = ($urandom_range(0, 2) != 0);
        if (dm_req) begin
          dm_we = 1'($urandom); dm_be = 4'($urandom);
          dm_addr = $urandom; dm_wdata = $urandom;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
